hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS datapath. Drives the write-enable and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. Resolves four conditions: load-use stalls, taken-branch flushes from EX, jump flushes from ID, and multi-cycle data-memory waits with a timeout. Also keeps saturating stall and flush performance counters.

---
 rtl/hazard_ctrl_pkg.sv | 27 ++
 rtl/sat_counter.sv | 21 ++
 rtl/hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_hazard_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller.
// Holds the sequencing FSM encoding and the idle values of the control vectors.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    typedef struct packed {
        logic pc;
        logic if_id;
        logic id_ex;
        logic ex_mem;
    } wen_t;

    typedef struct packed {
        logic if_id;
        logic id_ex;
        logic mem_wb;
    } flush_t;

    localparam wen_t   WEN_DEFAULT   = wen_t'(4'b1111);
    localparam flush_t FLUSH_DEFAULT = flush_t'(3'b000);

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    // NOTE: sequential state is always updated with non-blocking assignments.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch/jump flushes,
// data-memory wait freeze with timeout-to-HALT, and saturating perf counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       IF_ID_rs,
    input  logic [4:0]       IF_ID_rt,
    input  logic             ID_uses_rt,
    input  logic             ID_jump,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_rt,
    input  logic             EX_branch_taken,
    input  logic             EX_MEM_mem_access,
    input  logic             mem_ready,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             ID_EX_write,
    output logic             EX_MEM_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             MEM_WB_flush,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             mem_timeout_err
);

    localparam int WW = $clog2(MEM_TIMEOUT);

    state_t        state, state_nxt;
    logic [WW-1:0] wait_cnt, wait_cnt_nxt;
    logic          err;
    logic          freeze, lu, lu_stall;
    wen_t          wen;
    flush_t        fl;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        freeze   = 1'b0;
        lu       = 1'b0;
        lu_stall = 1'b0;
        wen      = WEN_DEFAULT;
        fl       = FLUSH_DEFAULT;

        freeze = ((state == RUN) && EX_MEM_mem_access && !mem_ready) ||
                 ((state == MEM_WAIT) && !mem_ready) ||
                 (state == HALT);
        lu = ID_EX_MemRead && (ID_EX_rt != 5'd0) &&
             ((ID_EX_rt == IF_ID_rs) || (ID_uses_rt && (ID_EX_rt == IF_ID_rt)));

        // Priority: freeze > branch > load-use > jump.
        if (!reset) begin
            wen = '0;
            fl  = '0;
        end else if (freeze) begin
            wen       = '0;
            fl.mem_wb = 1'b1;
        end else if (EX_branch_taken) begin
            fl.if_id = 1'b1;
            fl.id_ex = 1'b1;
        end else if (lu) begin
            wen.pc    = 1'b0;
            wen.if_id = 1'b0;
            fl.id_ex  = 1'b1;
            lu_stall  = 1'b1;
        end else if (ID_jump) begin
            fl.if_id = 1'b1;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            RUN: begin
                if (EX_MEM_mem_access && !mem_ready) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = WW'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == WW'(MEM_TIMEOUT - 1)) begin
                    state_nxt = HALT;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (state_nxt == HALT) begin
                err <= 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (freeze | lu_stall),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (fl.if_id),
        .count (flush_count)
    );

    assign PC_write        = wen.pc;
    assign IF_ID_write     = wen.if_id;
    assign ID_EX_write     = wen.id_ex;
    assign EX_MEM_write    = wen.ex_mem;
    assign IF_ID_flush     = fl.if_id;
    assign ID_EX_flush     = fl.id_ex;
    assign MEM_WB_flush    = fl.mem_wb;
    assign mem_timeout_err = err;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expected control/counter values are queued
// as each stimulus step is driven and popped when the outputs are sampled.
module tb_hazard_ctrl;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    // {PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, IF_ID_flush, ID_EX_flush, MEM_WB_flush}
    localparam logic [6:0] C_DEF = 7'b1111_000;
    localparam logic [6:0] C_FRZ = 7'b0000_001;
    localparam logic [6:0] C_LU  = 7'b0011_010;
    localparam logic [6:0] C_BR  = 7'b1111_110;
    localparam logic [6:0] C_JMP = 7'b1111_100;
    localparam logic [6:0] C_RST = 7'b0000_000;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       jump;
        logic       memread;
        logic [4:0] ex_rt;
        logic       br;
        logic       access;
        logic       ready;
    } stim_t;

    typedef struct packed {
        logic [6:0]       ctrl;
        logic [CNT_W-1:0] stall;
        logic [CNT_W-1:0] flush;
        logic             err;
    } exp_t;

    logic             clk, reset;
    logic [4:0]       IF_ID_rs, IF_ID_rt, ID_EX_rt;
    logic             ID_uses_rt, ID_jump, ID_EX_MemRead, EX_branch_taken;
    logic             EX_MEM_mem_access, mem_ready;
    logic             PC_write, IF_ID_write, ID_EX_write, EX_MEM_write;
    logic             IF_ID_flush, ID_EX_flush, MEM_WB_flush;
    logic [CNT_W-1:0] stall_count, flush_count;
    logic             mem_timeout_err;
    logic [6:0]       obs_ctrl;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_stall  = 0;
    int   m_flush  = 0;

    hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .IF_ID_rs          (IF_ID_rs),
        .IF_ID_rt          (IF_ID_rt),
        .ID_uses_rt        (ID_uses_rt),
        .ID_jump           (ID_jump),
        .ID_EX_MemRead     (ID_EX_MemRead),
        .ID_EX_rt          (ID_EX_rt),
        .EX_branch_taken   (EX_branch_taken),
        .EX_MEM_mem_access (EX_MEM_mem_access),
        .mem_ready         (mem_ready),
        .PC_write          (PC_write),
        .IF_ID_write       (IF_ID_write),
        .ID_EX_write       (ID_EX_write),
        .EX_MEM_write      (EX_MEM_write),
        .IF_ID_flush       (IF_ID_flush),
        .ID_EX_flush       (ID_EX_flush),
        .MEM_WB_flush      (MEM_WB_flush),
        .stall_count       (stall_count),
        .flush_count       (flush_count),
        .mem_timeout_err   (mem_timeout_err)
    );

    assign obs_ctrl = {PC_write, IF_ID_write, ID_EX_write, EX_MEM_write,
                       IF_ID_flush, ID_EX_flush, MEM_WB_flush};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s       = '0;
        s.ready = 1'b1;
        return s;
    endfunction

    // lw $8 in EX, add $9,$8,$1 in ID
    function automatic stim_t lu_stim();
        stim_t s;
        s         = idle();
        s.rs      = 5'd8;
        s.rt      = 5'd1;
        s.uses_rt = 1'b1;
        s.memread = 1'b1;
        s.ex_rt   = 5'd8;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        IF_ID_rs          = s.rs;
        IF_ID_rt          = s.rt;
        ID_uses_rt        = s.uses_rt;
        ID_jump           = s.jump;
        ID_EX_MemRead     = s.memread;
        ID_EX_rt          = s.ex_rt;
        EX_branch_taken   = s.br;
        EX_MEM_mem_access = s.access;
        mem_ready         = s.ready;
    endtask

    // One pipeline cycle: drive at negedge, compare 2 time units later.
    task automatic step(input string tag, input stim_t s, input logic [6:0] ctrl, input logic err_e);
        exp_t e;
        @(negedge clk);
        drive(s);
        e.ctrl  = ctrl;
        e.stall = CNT_W'(m_stall);
        e.flush = CNT_W'(m_flush);
        e.err   = err_e;
        exp_q.push_back(e);
        #2;
        e = exp_q.pop_front();
        check({tag, "_ctrl"},  32'(obs_ctrl),        32'(e.ctrl));
        check({tag, "_stall"}, 32'(stall_count),     32'(e.stall));
        check({tag, "_flush"}, 32'(flush_count),     32'(e.flush));
        check({tag, "_err"},   32'(mem_timeout_err), 32'(e.err));
        if ((e.ctrl == C_FRZ) || (e.ctrl == C_LU)) begin
            if (m_stall < CNT_MAX) m_stall++;
        end
        if (e.ctrl[2]) begin
            if (m_flush < CNT_MAX) m_flush++;
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b0;
        drive(idle());
        #2;
        check({tag, "_ctrl"},  32'(obs_ctrl),        32'(C_RST));
        check({tag, "_stall"}, 32'(stall_count),     32'd0);
        check({tag, "_flush"}, 32'(flush_count),     32'd0);
        check({tag, "_err"},   32'(mem_timeout_err), 32'd0);
        m_stall = 0;
        m_flush = 0;
        @(negedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        stim_t s;
        reset = 1'b0;
        drive(idle());
        #2;
        check("reset_ctrl",  32'(obs_ctrl),        32'(C_RST));
        check("reset_stall", 32'(stall_count),     32'd0);
        check("reset_flush", 32'(flush_count),     32'd0);
        check("reset_err",   32'(mem_timeout_err), 32'd0);
        @(negedge clk);
        #1 reset = 1'b1;

        // Load-use and its non-matching variants
        step("idle0", idle(), C_DEF, 1'b0);
        step("lu", lu_stim(), C_LU, 1'b0);
        step("lu_after", idle(), C_DEF, 1'b0);
        check("lu_stall_is_1", 32'(stall_count), 32'd1);
        s = lu_stim(); s.ex_rt = 5'd0; s.rs = 5'd0;
        step("lu_rt0", s, C_DEF, 1'b0);
        s = lu_stim(); s.rs = 5'd3; s.rt = 5'd8; s.uses_rt = 1'b0;
        step("lu_no_rt", s, C_DEF, 1'b0);
        s.uses_rt = 1'b1;
        step("lu_via_rt", s, C_LU, 1'b0);

        // Branch beats load-use
        do_reset("rst_br");
        s = lu_stim(); s.br = 1'b1;
        step("br_lu", s, C_BR, 1'b0);
        step("br_after", idle(), C_DEF, 1'b0);
        check("br_flush_is_1", 32'(flush_count), 32'd1);
        check("br_stall_is_0", 32'(stall_count), 32'd0);

        // Load-use beats jump; jump flushes once re-presented
        s = lu_stim(); s.jump = 1'b1;
        step("jmp_lu", s, C_LU, 1'b0);
        s = idle(); s.jump = 1'b1;
        step("jmp_retry", s, C_JMP, 1'b0);
        step("jmp_after", idle(), C_DEF, 1'b0);

        // Memory wait: 3 frozen cycles, release on the fourth
        do_reset("rst_mem");
        s = idle(); s.access = 1'b1; s.ready = 1'b1;
        step("mem_ready_entry", s, C_DEF, 1'b0);
        s.ready = 1'b0;
        for (int i = 0; i < 3; i++) step("mem_wait", s, C_FRZ, 1'b0);
        s.ready = 1'b1;
        step("mem_release", s, C_DEF, 1'b0);
        step("mem_after", idle(), C_DEF, 1'b0);
        check("mem_stall_is_3", 32'(stall_count), 32'd3);

        // Timeout: MEM_TIMEOUT wait cycles then sticky HALT
        do_reset("rst_to");
        s = idle(); s.access = 1'b1; s.ready = 1'b0;
        for (int i = 0; i < MEM_TIMEOUT; i++) step("to_wait", s, C_FRZ, 1'b0);
        step("to_halt", s, C_FRZ, 1'b1);
        step("to_halt_ready", idle(), C_FRZ, 1'b1);
        s = lu_stim(); s.br = 1'b1;
        step("to_halt_br", s, C_FRZ, 1'b1);
        do_reset("rst_halt");
        step("after_halt", idle(), C_DEF, 1'b0);

        // Saturation of the stall counter
        for (int i = 0; i < 20; i++) step("sat_lu", lu_stim(), C_LU, 1'b0);
        step("sat_after", idle(), C_DEF, 1'b0);
        check("sat_stall_15", 32'(stall_count), 32'(CNT_MAX));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
